mem_burst_sched: RTL



---
 rtl/mem_burst_sched.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_burst_sched.sv
// Burst scheduler between ADC capture (memory writes) and filter input (memory reads).
// Latency: grant -> cmd_valid 1 cycle; last beat -> addr_up pulse 1 cycle; >=1 IDLE cycle between bursts.
// Backpressure: cmd_valid held until cmd_ready; optional watchdog via `define MEM_SCHED_TIMEOUT_EN.
module mem_burst_sched #(
    parameter int ADDR_W    = 25,
    parameter int LVL_W     = 10,
    parameter int BURST_LEN = 256
`ifdef MEM_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LVL_W-1:0]  wr_fifo_level,
    input  logic [LVL_W-1:0]  rd_fifo_space,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              read_en,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              mem_beat,
    output logic              wr_addr_up,
    output logic              rd_addr_up,
    output logic              frist_block,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST, S_UPDATE} state_t;

    localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0] LAST_BEAT = LVL_W'(BURST_LEN - 1);

    state_t              state_q, state_d;
    logic [LVL_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                last_wr_q, last_wr_d;     // last_grant: 1 = WRITE, 0 = READ
    logic                cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic                frist_block_q, frist_block_d;
    logic                wd_expire;

    // Pending terms only matter in IDLE; REQ/BURST ignore them entirely.
    logic wr_pend, rd_pend, grant_wr;
    assign wr_pend  = wr_fifo_level >= BURST_LVL;
    assign rd_pend  = read_en & ~frist_block_q & (rd_fifo_space >= BURST_LVL);
    // On a tie, alternate away from the previous grant (reset value READ makes the first tie a write).
    assign grant_wr = wr_pend & (~rd_pend | ~last_wr_q);

`ifdef MEM_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            err_q, err_d;
    logic            wd_active, wd_kick;

    assign wd_active = (state_q == S_REQ) || (state_q == S_BURST);
    assign wd_kick   = cmd_ready | mem_beat;
    assign wd_expire = wd_active & ~wd_kick & (wd_cnt_q == WD_LAST);

    // Watchdog: count stalled cycles in REQ/BURST, restart on any handshake or beat.
    always_comb begin
        wd_cnt_d = '0;
        err_d    = err_q | wd_expire;
        if (wd_active && !wd_kick && !wd_expire) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    // Watchdog state; err is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state logic: grant in IDLE, handshake in REQ, beat counting in BURST, one-cycle UPDATE.
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        last_wr_d     = last_wr_q;
        cmd_wr_d      = cmd_wr_q;
        cmd_addr_d    = cmd_addr_q;
        frist_block_d = frist_block_q;
        case (state_q)
            S_IDLE: begin
                if (wr_pend || rd_pend) begin
                    state_d    = S_REQ;
                    cmd_wr_d   = grant_wr;
                    last_wr_d  = grant_wr;
                    cmd_addr_d = grant_wr ? wr_addr : rd_addr;
                end
            end
            S_REQ: begin
                // A beat coinciding with the handshake is not part of the count.
                if (cmd_ready) begin
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (mem_beat) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = S_UPDATE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            S_UPDATE: begin
                // Once any write has landed, reads are allowed for good.
                if (cmd_wr_q) begin
                    frist_block_d = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A stalled transfer is abandoned with no address advance.
        if (wd_expire) begin
            state_d    = S_IDLE;
            beat_cnt_d = '0;
        end
    end

    // Scheduler state registers; reset discards any partial burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            beat_cnt_q    <= '0;
            last_wr_q     <= 1'b0;
            cmd_wr_q      <= 1'b0;
            cmd_addr_q    <= '0;
            frist_block_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            last_wr_q     <= last_wr_d;
            cmd_wr_q      <= cmd_wr_d;
            cmd_addr_q    <= cmd_addr_d;
            frist_block_q <= frist_block_d;
        end
    end

    // Outputs decode directly from registered state, so pulses are exclusive by construction.
    assign cmd_valid   = (state_q == S_REQ);
    assign cmd_wr      = cmd_wr_q;
    assign cmd_addr    = cmd_addr_q;
    assign wr_addr_up  = (state_q == S_UPDATE) &  cmd_wr_q;
    assign rd_addr_up  = (state_q == S_UPDATE) & ~cmd_wr_q;
    assign frist_block = frist_block_q;
    assign busy        = (state_q != S_IDLE);

endmodule
